// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, per-result flag bundle and
// default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_PASS = 4'd7
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

  // Codes 8..15 have no operation assigned.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands and opcode in, result and flags out.
// Sits between the operand register stage and the result register stage.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        op_i,
  output logic [DATA_W-1:0] res_o,
  output flags_t            flags_o
);

  localparam int SHW = $clog2(DATA_W);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [SHW-1:0]    shamt;
  logic              a_msb;
  logic              b_msb;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  // The extra top bit of the unsigned difference is exactly the borrow (a < b).
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHW-1:0];
  assign a_msb = a_i[DATA_W-1];
  assign b_msb = b_i[DATA_W-1];

  always_comb begin
    res_o         = '0;
    flags_o       = '0;
    if (op_is_illegal(op_i)) begin
      flags_o.err = 1'b1;
    end else begin
      case (op_e'(op_i))
        OP_ADD: begin
          res_o         = sum[DATA_W-1:0];
          flags_o.carry = sum[DATA_W];
          flags_o.ovf   = (a_msb == b_msb) && (sum[DATA_W-1] != a_msb);
        end
        OP_SUB: begin
          res_o         = diff[DATA_W-1:0];
          flags_o.carry = diff[DATA_W];
          flags_o.ovf   = (a_msb != b_msb) && (diff[DATA_W-1] != a_msb);
        end
        OP_AND:  res_o = a_i & b_i;
        OP_OR:   res_o = a_i | b_i;
        OP_XOR:  res_o = a_i ^ b_i;
        OP_SHL:  res_o = a_i << shamt;
        OP_SHR:  res_o = a_i >> shamt;
        OP_PASS: res_o = a_i;
        default: res_o = '0;
      endcase
      flags_o.zero = (res_o == '0);
      flags_o.neg  = res_o[DATA_W-1];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: stage 1 holds the
// operands, stage 2 holds result and flags; also counts completed outputs.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf,
  output logic              out_err,
  output logic [CNT_W-1:0]  op_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds payload stable while valid && !ready, and
  // ready may depend combinationally on the downstream ready.
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_b_q,     s1_b_d;
  logic [3:0]        s1_op_q,    s1_op_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_res_q,   s2_res_d;
  flags_t            s2_flags_q, s2_flags_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              in_hs;
  logic              out_hs;
  logic [DATA_W-1:0] core_res;
  flags_t            core_flags;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .op_i    (s1_op_q),
    .res_o   (core_res),
    .flags_o (core_flags)
  );

  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign in_hs  = in_valid && s1_adv;
  assign out_hs = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    cnt_d      = cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_hs) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = in_op;
      end
    end

    // A bubble moving into stage 2 leaves the last result on the pins.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d   = core_res;
        s2_flags_d = core_flags;
      end
    end

    if (out_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_carry = s2_flags_q.carry;
  assign out_zero  = s2_flags_q.zero;
  assign out_neg   = s2_flags_q.neg;
  assign out_ovf   = s2_flags_q.ovf;
  assign out_err   = s2_flags_q.err;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus random valid/ready traffic,
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int RW = DW + 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [3:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_res;
  logic          out_carry, out_zero, out_neg, out_ovf, out_err;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  logic [RW-1:0] exp_q[$];
  int            age_q[$];
  int            cnt_m = 0;

  alu_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    age_q.delete();
    cnt_m = 0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // reference model: {res, carry, zero, neg, ovf, err}
  function automatic logic [RW-1:0] ref_alu(input int a, input int b, input int op);
    int r, sa, sb, s;
    bit c, v, e;
    r = 0; c = 0; v = 0; e = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r > 255); r = r % 256; s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 8)) % 256;
      6: r = a >> (b % 8);
      7: r = a;
      default: e = 1;
    endcase
    return {r[7:0], c, (!e && r == 0), (!e && r >= 128), v, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] dut_out();
    return {out_res, out_carry, out_zero, out_neg, out_ovf, out_err};
  endfunction

  // driver: one cycle, entered and left at a falling edge
  task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [3:0] op, input logic ordy, output logic acc);
    logic exp_rdy, exp_ov, pop;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() < 2) || ordy;
    exp_ov  = (exp_q.size() > 0) && (age_q[0] >= 2);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("op_count", {28'd0, op_count}, cnt_m);
    if (exp_ov) chk("result", {19'd0, dut_out()}, {19'd0, exp_q[0]});
    acc = v && exp_rdy;
    pop = exp_ov && ordy;
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      void'(age_q.pop_front());
      cnt_m = (cnt_m + 1) % 16;
    end
    foreach (age_q[i]) age_q[i]++;
    if (acc) begin
      exp_q.push_back(ref_alu(a, b, op));
      age_q.push_back(1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, '0, ordy, acc);
  endtask

  task automatic single(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] op, input logic [RW-1:0] want);
    int lat;
    logic acc;
    step(1'b1, a, b, op, 1'b1, acc);
    lat = 1;
    while (!out_valid && lat < 8) begin
      idle(1'b1);
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_value"}, {19'd0, dut_out()}, {19'd0, want});
    idle(1'b1);
  endtask

  initial begin
    logic acc;
    logic [DW-1:0] r0;
    logic pv;
    logic [DW-1:0] pa, pb;
    logic [3:0] pop_code;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_res", {24'd0, out_res}, 0);
    chk("rst_flags", {27'd0, out_carry, out_zero, out_neg, out_ovf, out_err}, 0);
    chk("rst_op_count", {28'd0, op_count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    do_reset();

    // directed single operations
    single("add_ff_01", 8'hFF, 8'h01, 4'd0, {8'h00, 5'b11000});
    single("sub_80_01", 8'h80, 8'h01, 4'd1, {8'h7F, 5'b00010});
    single("sub_01_02", 8'h01, 8'h02, 4'd1, {8'hFF, 5'b10100});
    single("shl_81_09", 8'h81, 8'h09, 4'd5, {8'h02, 5'b00000});
    single("shr_80_07", 8'h80, 8'h07, 4'd6, {8'h01, 5'b00000});
    single("illegal_c", 8'h33, 8'h44, 4'hC, {8'h00, 5'b00001});

    // back-pressure: three ops with out_ready low
    do_reset();
    step(1'b1, 8'h01, 8'h02, 4'd0, 1'b0, acc);
    step(1'b1, 8'h0F, 8'hF0, 4'd4, 1'b0, acc);
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h00; in_op = 4'd7; out_ready = 1'b0;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    r0 = out_res;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h5A, 8'h00, 4'd7, 1'b0, acc);
      chk("stall_stable", {24'd0, out_res}, {24'd0, r0});
    end
    step(1'b1, 8'h5A, 8'h00, 4'd7, 1'b1, acc);
    chk("release_accept", {31'd0, acc}, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("count_three", {28'd0, op_count}, 3);

    // reset while both stages hold data
    step(1'b1, 8'h11, 8'h22, 4'd0, 1'b0, acc);
    step(1'b1, 8'h33, 8'h44, 4'd3, 1'b0, acc);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_op_count", {28'd0, op_count}, 0);
    chk("midrst_out_res", {24'd0, out_res}, 0);
    exp_q.delete();
    age_q.delete();
    cnt_m = 0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    single("post_reset_add", 8'h10, 8'h20, 4'd0, {8'h30, 5'b00000});

    // counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++)
      step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1, acc);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("count_wrap", {28'd0, op_count}, 1);

    // random traffic with held offers
    pv = 1'b0; pa = '0; pb = '0; pop_code = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv) begin
        pv       = ($urandom_range(0, 3) != 0);
        pa       = 8'($urandom_range(0, 255));
        pb       = 8'($urandom_range(0, 255));
        pop_code = 4'($urandom_range(0, 15));
      end
      step(pv, pa, pb, pop_code, ($urandom_range(0, 3) != 0), acc);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
